uart_arbitro_tx: RTL and testbench

Sequencer and arbiter that shares the single UART peripheral (register interface: `reg_sel`, `wr`, 32-bit write bus, 32-bit read bus) between two byte-transmit requesters. It also drains received bytes from the peripheral. It sits between the requesters (switch/button control logic, a second data source) and `top_UART`, replacing direct register-level access by any requester.

---
 rtl/uart_arbitro_tx_pkg.sv | 23 ++
 rtl/uart_arbitro_tx_rr2.sv | 20 ++
 rtl/uart_arbitro_tx.sv | 143 ++++++++++++++
 tb/tb_uart_arbitro_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arbitro_tx_pkg.sv
// Shared types and register-map constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ESCRIBE_DATO,
    ESCRIBE_CTRL,
    ESPERA_TX,
    ACK,
    LEE_RX,
    LIMPIA_RX
  } estado_e;

  localparam logic REG_CTRL = 1'b0;
  localparam logic REG_DATO = 1'b1;

  localparam int BIT_ENVIAR   = 0;
  localparam int BIT_NUEVO_RX = 1;

  localparam logic [31:0] CTRL_ENVIAR  = 32'h1;
  localparam logic [31:0] CTRL_LIMPIAR = 32'h0;

endpackage

// File: rtl/uart_arbitro_tx_rr2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to the
// requester that was not served last.
module arbitro_rr2 (
  input  logic [1:0] req_i,
  input  logic       ultimo_i,
  output logic       grant_o,
  output logic       valido_o
);

  always_comb begin
    valido_o = |req_i;
    case (req_i)
      2'b01:   grant_o = 1'b0;
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~ultimo_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_arbitro_tx.sv
// Sequencer sharing one UART register interface between two byte-transmit
// requesters; received bytes are drained with priority over transmissions.
module uart_arbitro_tx
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 100000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [1:0]  req_i,
  input  logic [7:0]  dato0_i,
  input  logic [7:0]  dato1_i,
  output logic [1:0]  ack_o,
  output logic [7:0]  dato_recibido_o,
  output logic        dato_valido_o,
  output logic        ocupado_o,
  output logic        error_o,
  output logic        wr_o,
  output logic        reg_sel_o,
  output logic [31:0] entrada_perif_UART_o,
  input  logic [31:0] salida_perif_UART_i
);

  localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(TIMEOUT_CICLOS - 1);

  estado_e           estado_q;
  logic              grant_q;
  logic              ultimo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [1:0]        ack_q;
  logic [7:0]        dato_rx_q;
  logic              valido_q;
  logic              error_q;
  logic              wr_q;
  logic              sel_q;
  logic [31:0]       bus_q;

  logic              arb_grant;
  logic              arb_valido;
  logic [7:0]        dato_sel;
  logic              unused_salida;

  arbitro_rr2 u_arb (
    .req_i    (req_i),
    .ultimo_i (ultimo_q),
    .grant_o  (arb_grant),
    .valido_o (arb_valido)
  );

  assign dato_sel      = arb_grant ? dato1_i : dato0_i;
  assign cnt_d         = cnt_q + CNT_W'(1);
  assign unused_salida = ^salida_perif_UART_i[31:8];

  // Peripheral-facing outputs are set on entry to each state so they stay
  // registered and line up exactly with the state they belong to.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      estado_q  <= IDLE;
      grant_q   <= 1'b0;
      ultimo_q  <= 1'b1;
      cnt_q     <= '0;
      ack_q     <= '0;
      dato_rx_q <= '0;
      valido_q  <= 1'b0;
      error_q   <= 1'b0;
      wr_q      <= 1'b0;
      sel_q     <= REG_CTRL;
      bus_q     <= '0;
    end else begin
      ack_q    <= '0;
      valido_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          if (salida_perif_UART_i[BIT_NUEVO_RX]) begin
            wr_q     <= 1'b0;
            sel_q    <= REG_DATO;
            estado_q <= LEE_RX;
          end else if (arb_valido) begin
            grant_q  <= arb_grant;
            bus_q    <= {24'h0, dato_sel};
            wr_q     <= 1'b1;
            sel_q    <= REG_DATO;
            estado_q <= ESCRIBE_DATO;
          end
        end
        ESCRIBE_DATO: begin
          bus_q    <= CTRL_ENVIAR;
          wr_q     <= 1'b1;
          sel_q    <= REG_CTRL;
          estado_q <= ESCRIBE_CTRL;
        end
        ESCRIBE_CTRL: begin
          cnt_q    <= '0;
          wr_q     <= 1'b0;
          sel_q    <= REG_CTRL;
          estado_q <= ESPERA_TX;
        end
        ESPERA_TX: begin
          if (!salida_perif_UART_i[BIT_ENVIAR]) begin
            ack_q    <= grant_q ? 2'b10 : 2'b01;
            estado_q <= ACK;
          end else if (cnt_q == CNT_FIN) begin
            error_q  <= 1'b1;
            ack_q    <= grant_q ? 2'b10 : 2'b01;
            estado_q <= ACK;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ACK: begin
          ultimo_q <= grant_q;
          estado_q <= IDLE;
        end
        LEE_RX: begin
          dato_rx_q <= salida_perif_UART_i[7:0];
          valido_q  <= 1'b1;
          bus_q     <= CTRL_LIMPIAR;
          wr_q      <= 1'b1;
          sel_q     <= REG_CTRL;
          estado_q  <= LIMPIA_RX;
        end
        LIMPIA_RX: begin
          wr_q     <= 1'b0;
          sel_q    <= REG_CTRL;
          estado_q <= IDLE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign ack_o                = ack_q;
  assign dato_recibido_o      = dato_rx_q;
  assign dato_valido_o        = valido_q;
  assign ocupado_o            = (estado_q != IDLE);
  assign error_o              = error_q;
  assign wr_o                 = wr_q;
  assign reg_sel_o            = sel_q;
  assign entrada_perif_UART_o = bus_q;

endmodule

// File: tb/tb_uart_arbitro_tx.sv
// Bench for uart_arbitro_tx: behavioural UART register model, write/RX
// scoreboard queues, a vector table of transmit scenarios and corner sequences.
module tb_uart_arbitro_tx;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [1:0]  req;
  logic [7:0]  d0, d1;
  logic [1:0]  ack_o;
  logic [7:0]  dato_recibido_o;
  logic        dato_valido_o, ocupado_o, error_o, wr_o, reg_sel_o;
  logic [31:0] bus_o;
  logic [31:0] salida;

  always #5 clk = ~clk;

  uart_arbitro_tx #(.TIMEOUT_CICLOS(50)) dut (
    .clk_i                (clk),
    .reset_i              (reset_i),
    .req_i                (req),
    .dato0_i              (d0),
    .dato1_i              (d1),
    .ack_o                (ack_o),
    .dato_recibido_o      (dato_recibido_o),
    .dato_valido_o        (dato_valido_o),
    .ocupado_o            (ocupado_o),
    .error_o              (error_o),
    .wr_o                 (wr_o),
    .reg_sel_o            (reg_sel_o),
    .entrada_perif_UART_o (bus_o),
    .salida_perif_UART_i  (salida)
  );

  // Peripheral model: control bits {nuevo_rx, enviar}, enviar self-clears
  // tx_lat cycles after it becomes visible.
  logic [1:0] ctrl;
  logic [7:0] rx_data;
  int         tx_timer;
  int         tx_lat = 10;
  int         rx_inj = 0;
  int         rx_seen = 0;
  logic [7:0] rx_inj_byte = 8'h00;

  assign salida = reg_sel_o ? {24'h0, rx_data} : {30'h0, ctrl};

  always @(posedge clk) begin
    if (reset_i) begin
      ctrl     <= 2'b00;
      rx_data  <= 8'h00;
      tx_timer <= 0;
      rx_seen  <= rx_inj;
    end else begin
      if (wr_o && !reg_sel_o) begin
        ctrl <= bus_o[1:0];
        if (bus_o[0]) tx_timer <= tx_lat;
      end else if (ctrl[0]) begin
        if (tx_timer <= 1) ctrl[0] <= 1'b0;
        else tx_timer <= tx_timer - 1;
      end
      if (rx_inj != rx_seen) begin
        ctrl[1] <= 1'b1;
        rx_data <= rx_inj_byte;
        rx_seen <= rx_inj;
      end
    end
  end

  typedef struct {
    logic        sel;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    int         lat;
    logic       first_id;
    logic [7:0] b1;
    logic [7:0] b2;
    int         ack1;
  } vec_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rx[$];
  int         nvec = 0;
  int         nerr = 0;
  int         cyc;
  int         ack_t[2];
  int         val_t;
  vec_t       vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, expv);
    end
  endtask

  task automatic push_wr(input logic sel, input logic [31:0] data);
    wr_t w;
    w.sel  = sel;
    w.data = data;
    exp_wr.push_back(w);
  endtask

  // One clock: sample after the edge, score writes/RX, play the requesters.
  task automatic step();
    wr_t        e;
    logic [7:0] r;
    @(posedge clk);
    #1;
    cyc++;
    if (wr_o === 1'b1) begin
      if (exp_wr.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL wr_unexpected: got sel=%0b data='h%0h, expected no write", reg_sel_o, bus_o);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_sel", 32'(reg_sel_o), 32'(e.sel));
        chk("wr_data", bus_o, e.data);
      end
    end
    if (dato_valido_o === 1'b1) begin
      val_t = cyc;
      if (exp_rx.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL rx_unexpected: got 'h%0h, expected no reception", dato_recibido_o);
      end else begin
        r = exp_rx.pop_front();
        chk("rx_byte", 32'(dato_recibido_o), 32'(r));
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (ack_o[k] === 1'b1) begin
        ack_t[k] = cyc;
        if (req[k] !== 1'b1) begin
          nvec++;
          nerr++;
          $display("FAIL ack_unexpected: got ack_o[%0d]=1, expected 0", k);
        end
        req[k] = 1'b0;
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((req != 2'b00 || exp_wr.size() != 0 || exp_rx.size() != 0 || ocupado_o !== 1'b0)
           && n < budget) begin
      step();
      n++;
    end
    nvec++;
    if (n >= budget) begin
      nerr++;
      $display("FAIL drain: still busy after %0d cycles, expected idle", n);
      exp_wr.delete();
      exp_rx.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, 32'(ack_o), 32'h0);
    chk({tag, "_wr"}, 32'(wr_o), 32'h0);
    chk({tag, "_sel"}, 32'(reg_sel_o), 32'h0);
    chk({tag, "_bus"}, bus_o, 32'h0);
    chk({tag, "_busy"}, 32'(ocupado_o), 32'h0);
    chk({tag, "_err"}, 32'(error_o), 32'h0);
    chk({tag, "_rxd"}, 32'(dato_recibido_o), 32'h0);
    chk({tag, "_rxv"}, 32'(dato_valido_o), 32'h0);
  endtask

  initial begin
    vt[0] = '{2'b11, 8'h11, 8'h22, 10, 1'b0, 8'h11, 8'h22, 14};
    vt[1] = '{2'b01, 8'hA5, 8'h00, 10, 1'b0, 8'hA5, 8'h00, 14};
    vt[2] = '{2'b11, 8'h11, 8'h22, 10, 1'b1, 8'h22, 8'h11, 14};
    vt[3] = '{2'b10, 8'h00, 8'hC3, 3,  1'b1, 8'hC3, 8'h00, 7};
    vt[4] = '{2'b11, 8'h5A, 8'hE7, 1,  1'b0, 8'h5A, 8'hE7, 5};
    vt[5] = '{2'b11, 8'h0F, 8'hF0, 2,  1'b0, 8'h0F, 8'hF0, 6};

    reset_i = 1'b1;
    req = 2'b00;
    d0 = 8'h00;
    d1 = 8'h00;
    cyc = 0;
    val_t = -1;
    ack_t = '{-1, -1};
    repeat (3) step();
    chk_all_zero("reset");
    reset_i = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      cyc = 0;
      ack_t = '{-1, -1};
      tx_lat = vt[i].lat;
      d0 = vt[i].d0;
      d1 = vt[i].d1;
      req = vt[i].req;
      push_wr(1'b1, {24'h0, vt[i].b1});
      push_wr(1'b0, 32'h1);
      if (vt[i].req == 2'b11) begin
        push_wr(1'b1, {24'h0, vt[i].b2});
        push_wr(1'b0, 32'h1);
      end
      drain(400);
      chk($sformatf("v%0d_ack_first", i), ack_t[vt[i].first_id], vt[i].ack1);
      if (vt[i].req == 2'b11)
        chk($sformatf("v%0d_ack_second", i), ack_t[vt[i].first_id ? 0 : 1],
            vt[i].ack1 + vt[i].lat + 5);
    end
    chk("error_clean", 32'(error_o), 32'h0);

    // RX while idle: nuevo_rx visible on cycle 1, dato_valido two cycles later.
    cyc = 0;
    val_t = -1;
    rx_inj_byte = 8'h3C;
    rx_inj++;
    push_wr(1'b0, 32'h0);
    exp_rx.push_back(8'h3C);
    drain(50);
    chk("rx_valid_cyc", val_t, 3);
    chk("rx_hold", 32'(dato_recibido_o), 32'h3C);
    chk("rx_pulse_end", 32'(dato_valido_o), 32'h0);

    // RX and requester 1 arrive while requester 0 waits in ESPERA_TX.
    cyc = 0;
    val_t = -1;
    ack_t = '{-1, -1};
    tx_lat = 10;
    d0 = 8'h55;
    req = 2'b01;
    push_wr(1'b1, 32'h55);
    push_wr(1'b0, 32'h1);
    step();
    d0 = 8'hEE;
    repeat (3) step();
    req[1] = 1'b1;
    d1 = 8'h66;
    rx_inj_byte = 8'h77;
    rx_inj++;
    push_wr(1'b0, 32'h0);
    push_wr(1'b1, 32'h66);
    push_wr(1'b0, 32'h1);
    exp_rx.push_back(8'h77);
    drain(200);
    chk("mid_ack0", ack_t[0], 14);
    chk("mid_rx_valid", val_t, 17);
    chk("mid_ack1", ack_t[1], 32);

    // Reset while waiting for enviar: transfer abandoned, no ack.
    cyc = 0;
    ack_t = '{-1, -1};
    d0 = 8'h42;
    req = 2'b01;
    push_wr(1'b1, 32'h42);
    push_wr(1'b0, 32'h1);
    repeat (5) step();
    chk("busy_in_wait", 32'(ocupado_o), 32'h1);
    reset_i = 1'b1;
    req = 2'b00;
    step();
    chk_all_zero("midreset");
    reset_i = 1'b0;
    repeat (20) step();
    chk("no_ack_after_reset", ack_t[0], 32'hFFFF_FFFF);
    chk("idle_after_reset", 32'(ocupado_o), 32'h0);

    // enviar never clears: 50 wait cycles, then error + ack.
    cyc = 0;
    ack_t = '{-1, -1};
    tx_lat = 1000000;
    d0 = 8'h99;
    req = 2'b01;
    push_wr(1'b1, 32'h99);
    push_wr(1'b0, 32'h1);
    drain(200);
    chk("timeout_ack", ack_t[0], 53);
    chk("timeout_err", 32'(error_o), 32'h1);
    repeat (10) step();
    chk("timeout_sticky", 32'(error_o), 32'h1);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    step();
    chk("timeout_cleared", 32'(error_o), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
